// File: rtl/rtf_video_fetch_ctrl_pkg.sv
// Shared definitions for the video FIFO refill scheduler: FSM state
// encodings, FIFO geometry and beat sizing, plus an address-align helper.
package rtf_video_fetch_ctrl_pkg;

  localparam int unsigned FIFO_WORDS     = 512;
  localparam int unsigned WORDS_PER_BEAT = 4;
  localparam int unsigned BEAT_BYTES     = 16;
  localparam int unsigned CNT_W          = $clog2(FIFO_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  // Byte address rounded down to a 128-bit beat boundary.
  function automatic logic [31:0] beat_align(input logic [31:0] a);
    return a & ~32'(BEAT_BYTES - 1);
  endfunction

endpackage

// File: rtl/rtf_fetch_adr_gen.sv
// Frame address walker: holds the current beat address and the number of
// beats left in the frame. Loads on vsync, steps on every acked beat.
module rtf_fetch_adr_gen
  import rtf_video_fetch_ctrl_pkg::*;
#(
  parameter int unsigned FB_AW = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             step,
  input  logic [31:0]      base_adr,
  input  logic [FB_AW-1:0] frame_beats,
  output logic [31:0]      adr_o,
  output logic             busy,
  output logic             last_beat
);

  logic [31:0]      adr_q, adr_d;
  logic [FB_AW-1:0] rem_q, rem_d;

  // Next address/remaining: a new frame overrides any beat acked on the same cycle.
  always_comb begin
    adr_d = adr_q;
    rem_d = rem_q;
    if (vsync) begin
      adr_d = beat_align(base_adr);
      rem_d = frame_beats;
    end else if (step && (rem_q != '0)) begin
      adr_d = adr_q + 32'(BEAT_BYTES);
      rem_d = rem_q - FB_AW'(1);
    end
  end

  // Address and beat-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      adr_q <= '0;
      rem_q <= '0;
    end else begin
      adr_q <= adr_d;
      rem_q <= rem_d;
    end
  end

  assign adr_o     = adr_q;
  assign busy      = (rem_q != '0);
  assign last_beat = (rem_q == FB_AW'(1));

endmodule

// File: rtl/rtf_video_fetch_ctrl.sv
// Refill scheduler for the 512x32 video pixel FIFO. Watches the FIFO fill
// level and issues fixed-length 128-bit burst reads that walk linearly through
// one frame; returned beats are written straight into the FIFO.
// Optional feature: define RTF_FETCH_UNDERRUN_EN to add underrun_cnt[15:0],
// a saturating count of cycles spent busy with an empty FIFO.
module rtf_video_fetch_ctrl
  import rtf_video_fetch_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned LOW_WATER = 256,
  parameter int unsigned FB_AW     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic [31:0]      base_adr,
  input  logic [FB_AW-1:0] frame_beats,
  input  logic [CNT_W-1:0] fifo_cnt,
  output logic             cyc_o,
  output logic             stb_o,
  output logic [31:0]      adr_o,
  input  logic             ack_i,
  input  logic [127:0]     dat_i,
  output logic             fifo_wr,
  output logic [127:0]     fifo_di,
  output logic             busy
`ifdef RTF_FETCH_UNDERRUN_EN
  ,
  output logic [15:0]      underrun_cnt
`endif
);

  // A burst started at the threshold must still fit in the FIFO; an
  // out-of-range LOW_WATER is clamped to the largest safe level.
  localparam int unsigned LW_MAX = FIFO_WORDS - 1 - WORDS_PER_BEAT * BURST_LEN;
  localparam int unsigned LW_EFF = (LOW_WATER > LW_MAX) ? LW_MAX : LOW_WATER;
  localparam logic [CNT_W-1:0] LW_CNT    = CNT_W'(LW_EFF);
  localparam logic [4:0]       LAST_BEAT = 5'(BURST_LEN - 1);

  fetch_state_t state_q, state_d;
  logic [4:0]   beat_cnt_q, beat_cnt_d;
  logic         beat_ack;
  logic         last_beat;

  assign cyc_o    = (state_q == ST_BURST);
  assign stb_o    = (state_q == ST_BURST);
  assign beat_ack = cyc_o & stb_o & ack_i;
  assign fifo_wr  = beat_ack;
  assign fifo_di  = dat_i;

  rtf_fetch_adr_gen #(
    .FB_AW (FB_AW)
  ) u_adr_gen (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .step        (beat_ack),
    .base_adr    (base_adr),
    .frame_beats (frame_beats),
    .adr_o       (adr_o),
    .busy        (busy),
    .last_beat   (last_beat)
  );

  // Next-state logic: start on low fill, end burst on length, end of frame or vsync.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (busy && (fifo_cnt <= LW_CNT) && !vsync) begin
          state_d    = ST_BURST;
          beat_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (vsync) begin
          state_d    = ST_HOLD;
          beat_cnt_d = '0;
        end else if (beat_ack) begin
          if ((beat_cnt_q == LAST_BEAT) || last_beat) begin
            state_d    = ST_HOLD;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 5'd1;
          end
        end
      end
      ST_HOLD: begin
        // One idle bus cycle lets fifo_cnt catch up with the last write.
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // FSM state and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef RTF_FETCH_UNDERRUN_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Underrun counter: vsync clears, otherwise saturating count of busy-and-empty cycles.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (vsync) begin
      underrun_cnt_d = '0;
    end else if (busy && (fifo_cnt == '0) && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_rtf_video_fetch_ctrl.sv
// Self-checking bench for rtf_video_fetch_ctrl (default parameters).
// Frames are described by base address and length; the expected write
// sequence, burst split and addresses are computed from those alone.
module tb_rtf_video_fetch_ctrl;

  localparam int BL = 8;
  localparam int LW = 256;

  logic         clk;
  logic         rst;
  logic         vsync;
  logic [31:0]  base_adr;
  logic [19:0]  frame_beats;
  logic [8:0]   fifo_cnt;
  logic         cyc_o;
  logic         stb_o;
  logic [31:0]  adr_o;
  logic         ack_i;
  logic [127:0] dat_i;
  logic         fifo_wr;
  logic [127:0] fifo_di;
  logic         busy;
`ifdef RTF_FETCH_UNDERRUN_EN
  logic [15:0]  underrun_cnt;
`endif

  int vec;
  int errs;

  rtf_video_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .vsync       (vsync),
    .base_adr    (base_adr),
    .frame_beats (frame_beats),
    .fifo_cnt    (fifo_cnt),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .adr_o       (adr_o),
    .ack_i       (ack_i),
    .dat_i       (dat_i),
    .fifo_wr     (fifo_wr),
    .fifo_di     (fifo_di),
    .busy        (busy)
`ifdef RTF_FETCH_UNDERRUN_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] align16(input logic [31:0] a);
    return {a[31:4], 4'h0};
  endfunction

  task automatic start_frame(input logic [31:0] base, input int n);
    vsync       = 1'b1;
    base_adr    = base;
    frame_beats = 20'(n);
    ack_i       = 1'b0;
    tick();
    vsync       = 1'b0;
    base_adr    = $urandom;
    frame_beats = 20'($urandom);
  endtask

  // Runs a frame to completion from the current point, checking every cycle.
  task automatic drain_frame(input logic [31:0] base, input int n,
                             input int ack_period, input int ack_pct,
                             input bit rand_cnt, output int nbursts,
                             output logic [31:0] last_adr, output int nwrites);
    logic [31:0] b;
    int written, blen, gap, cycles, cc, exp_len;
    logic cyc_prev;
    logic [8:0] cnt_last;
    b = align16(base);
    written = 0; blen = 0; gap = 0; cycles = 0; cc = 0;
    nbursts = 0; last_adr = '0; cyc_prev = 1'b0; cnt_last = fifo_cnt;
    while (1) begin
      cycles++;
      if (cycles > 20000) begin
        errs++;
        $display("FAIL timeout: frame stuck after %0d writes, required %0d", written, n);
        break;
      end
      vec++;
      if (busy !== (written < n)) begin
        errs++;
        $display("FAIL busy: got %b required %b (written %0d of %0d)", busy, written < n, written, n);
      end
      if (cyc_prev && !cyc_o) begin
        exp_len = (n - (written - blen) < BL) ? n - (written - blen) : BL;
        vec++;
        if (blen != exp_len) begin
          errs++;
          $display("FAIL burst_len: got %0d required %0d", blen, exp_len);
        end
      end
      if (cyc_o && !cyc_prev) begin
        nbursts++;
        if (rand_cnt) begin
          vec++;
          if (cnt_last > 9'(LW) || (written > 0 && gap < 2)) begin
            errs++;
            $display("FAIL burst_start: fifo_cnt %0d gap %0d, required cnt<=%0d gap>=2", cnt_last, gap, LW);
          end
        end else if (written > 0) begin
          vec++;
          if (gap != 2) begin
            errs++;
            $display("FAIL hold_gap: got %0d idle cycles required 2", gap);
          end
        end
        gap = 0; blen = 0; cc = 0;
      end
      if (!cyc_o) gap++;
      if (!cyc_o && written >= n) break;
      if (cyc_o) begin
        vec++;
        if (stb_o !== 1'b1 || adr_o !== b + 32'(written) * 32'd16) begin
          errs++;
          $display("FAIL bus_req: stb %b adr %h required stb 1 adr %h", stb_o, adr_o, b + 32'(written) * 32'd16);
        end
      end
      if (ack_period > 0) ack_i = cyc_o && ((cc % ack_period) == ack_period - 1);
      else ack_i = cyc_o && ($urandom_range(0, 99) < ack_pct);
      if (cyc_o) cc++;
      dat_i = {$urandom, $urandom, $urandom, $urandom};
      if (rand_cnt) fifo_cnt = 9'($urandom_range(0, 511));
      #1;
      vec++;
      if (fifo_wr !== (cyc_o && ack_i) || (fifo_wr && fifo_di !== dat_i)) begin
        errs++;
        $display("FAIL fifo_write: wr %b di %h required wr %b di %h", fifo_wr, fifo_di, cyc_o && ack_i, dat_i);
      end
      if (cyc_o && ack_i) begin
        last_adr = adr_o;
        written++;
        blen++;
      end
      cyc_prev = cyc_o;
      cnt_last = fifo_cnt;
      tick();
    end
    ack_i = 1'b0;
    fifo_cnt = 9'd0;
    nwrites = written;
    for (int i = 0; i < 6; i++) begin
      tick();
      vec++;
      if (cyc_o !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL idle_after_frame: cyc %b busy %b required 0 0", cyc_o, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ack_i = 1'b1;
    tick(); tick();
    vec++;
    if ({cyc_o, stb_o, fifo_wr, busy} !== 4'b0000 || adr_o !== 32'h0) begin
      errs++;
      $display("FAIL reset: cyc %b stb %b wr %b busy %b adr %h required all 0",
               cyc_o, stb_o, fifo_wr, busy, adr_o);
    end
`ifdef RTF_FETCH_UNDERRUN_EN
    vec++;
    if (underrun_cnt !== 16'h0) begin
      errs++;
      $display("FAIL reset_underrun: got %0d required 0", underrun_cnt);
    end
`endif
    rst = 1'b0; ack_i = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    logic [31:0] base, la;
    int nb, nw;
    base = $urandom;
    fifo_cnt = 9'd0;
    start_frame(base, 100);
    drain_frame(base, 100, 1, 100, 1'b0, nb, la, nw);
    vec++;
    if (nb != 13 || nw != 100 || la !== align16(base) + 32'h630) begin
      errs++;
      $display("FAIL full_frame: bursts %0d writes %0d last_adr %h required 13 100 %h",
               nb, nw, la, align16(base) + 32'h630);
    end
  endtask

  task automatic test_low_water();
    logic [31:0] base;
    base = $urandom;
    fifo_cnt = 9'd257;
    start_frame(base, 20);
    for (int i = 0; i < 8; i++) begin
      vec++;
      if (cyc_o !== 1'b0) begin
        errs++;
        $display("FAIL above_low_water: cyc %b required 0 at fifo_cnt 257", cyc_o);
      end
      tick();
    end
    fifo_cnt = 9'd256;
    tick();
    vec++;
    if (cyc_o !== 1'b1 || stb_o !== 1'b1 || adr_o !== align16(base)) begin
      errs++;
      $display("FAIL at_low_water: cyc %b stb %b adr %h required 1 1 %h", cyc_o, stb_o, adr_o, align16(base));
    end
  endtask

  // Continues from the burst left open by test_low_water.
  task automatic test_reset_mid_burst();
    ack_i = 1'b1;
    dat_i = {$urandom, $urandom, $urandom, $urandom};
    tick(); tick();
    rst = 1'b1;
    tick();
    vec++;
    if ({cyc_o, stb_o, fifo_wr, busy} !== 4'b0000 || adr_o !== 32'h0) begin
      errs++;
      $display("FAIL reset_mid_burst: cyc %b stb %b wr %b busy %b adr %h required all 0",
               cyc_o, stb_o, fifo_wr, busy, adr_o);
    end
    rst = 1'b0; ack_i = 1'b0; fifo_cnt = 9'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++;
      if (cyc_o !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL after_reset: cyc %b busy %b required 0 0", cyc_o, busy);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] base, la;
    int nb, nw;
    base = $urandom;
    fifo_cnt = 9'd0;
    start_frame(base, 40);
    drain_frame(base, 40, 3, 0, 1'b0, nb, la, nw);
    vec++;
    if (nb != 5 || nw != 40 || la !== align16(base) + 32'd624) begin
      errs++;
      $display("FAIL stall_frame: bursts %0d writes %0d last_adr %h required 5 40 %h",
               nb, nw, la, align16(base) + 32'd624);
    end
  endtask

  task automatic test_vsync_mid_burst();
    logic [31:0] a, b, la;
    int w, k, nb, nw;
    a = $urandom; b = $urandom;
    fifo_cnt = 9'd0;
    start_frame(a, 50);
    k = 0;
    while (!cyc_o && k < 10) begin tick(); k++; end
    vec++;
    if (cyc_o !== 1'b1) begin
      errs++;
      $display("FAIL burst_not_started: cyc %b required 1", cyc_o);
    end
    w = 0;
    for (int i = 0; i < 3; i++) begin
      ack_i = 1'b1;
      dat_i = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (fifo_wr) w++;
      tick();
    end
    ack_i = 1'b1; vsync = 1'b1; base_adr = b; frame_beats = 20'd37;
    #1;
    vec++;
    if (fifo_wr !== 1'b1) begin
      errs++;
      $display("FAIL ack_on_vsync: wr %b required 1", fifo_wr);
    end
    if (fifo_wr) w++;
    tick();
    vsync = 1'b0; ack_i = 1'b0; base_adr = $urandom; frame_beats = 20'($urandom);
    vec++;
    if (w != 4 || cyc_o !== 1'b0 || stb_o !== 1'b0 || adr_o !== align16(b) || busy !== 1'b1) begin
      errs++;
      $display("FAIL vsync_mid_burst: writes %0d cyc %b stb %b adr %h busy %b required 4 0 0 %h 1",
               w, cyc_o, stb_o, adr_o, busy, align16(b));
    end
    drain_frame(b, 37, 1, 100, 1'b0, nb, la, nw);
    vec++;
    if (nw != 37) begin
      errs++;
      $display("FAIL new_frame_len: writes %0d required 37", nw);
    end
  endtask

  task automatic test_random_frames();
    logic [31:0] base, la;
    int n, pct, nb, nw;
    for (int i = 0; i < 6; i++) begin
      base = (i == 0) ? 32'hFFFF_FF85 : $urandom;
      n    = $urandom_range(1, 60);
      pct  = $urandom_range(30, 100);
      fifo_cnt = 9'd0;
      start_frame(base, n);
      drain_frame(base, n, 0, pct, i[0], nb, la, nw);
      vec++;
      if (nb != (n + BL - 1) / BL || nw != n || la !== align16(base) + 32'(n - 1) * 32'd16) begin
        errs++;
        $display("FAIL random_frame%0d: bursts %0d writes %0d last_adr %h required %0d %0d %h",
                 i, nb, nw, la, (n + BL - 1) / BL, n, align16(base) + 32'(n - 1) * 32'd16);
      end
    end
  endtask

  task automatic test_frame_beats_zero();
    logic [31:0] base, la;
    int nb, nw;
    base = $urandom;
    fifo_cnt = 9'd0;
    start_frame(base, 0);
    drain_frame(base, 0, 1, 100, 1'b0, nb, la, nw);
    vec++;
    if (nb != 0 || nw != 0) begin
      errs++;
      $display("FAIL zero_frame: bursts %0d writes %0d required 0 0", nb, nw);
    end
  endtask

`ifdef RTF_FETCH_UNDERRUN_EN
  task automatic test_underrun();
    fifo_cnt = 9'd300;
    start_frame($urandom, 200);
    vec++;
    if (underrun_cnt !== 16'd0) begin
      errs++;
      $display("FAIL underrun_clear: got %0d required 0", underrun_cnt);
    end
    fifo_cnt = 9'd0;
    for (int i = 0; i < 10; i++) tick();
    fifo_cnt = 9'd300;
    vec++;
    if (underrun_cnt !== 16'd10) begin
      errs++;
      $display("FAIL underrun_count: got %0d required 10", underrun_cnt);
    end
    tick(); tick(); tick();
    vec++;
    if (underrun_cnt !== 16'd10) begin
      errs++;
      $display("FAIL underrun_hold: got %0d required 10", underrun_cnt);
    end
    start_frame($urandom, 0);
    vec++;
    if (underrun_cnt !== 16'd0) begin
      errs++;
      $display("FAIL underrun_vsync: got %0d required 0", underrun_cnt);
    end
    fifo_cnt = 9'd0;
    for (int i = 0; i < 5; i++) tick();
    vec++;
    if (underrun_cnt !== 16'd0 || cyc_o !== 1'b0) begin
      errs++;
      $display("FAIL underrun_idle: cnt %0d cyc %b required 0 0", underrun_cnt, cyc_o);
    end
  endtask
`endif

  initial begin
    vec = 0; errs = 0;
    rst = 1'b1; vsync = 1'b0; base_adr = '0; frame_beats = '0;
    fifo_cnt = 9'd0; ack_i = 1'b0; dat_i = '0;
    test_reset();
    test_full_frame();
    test_low_water();
    test_reset_mid_burst();
    test_stall();
    test_vsync_mid_burst();
    test_random_frames();
    test_frame_beats_zero();
`ifdef RTF_FETCH_UNDERRUN_EN
    test_underrun();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
